// File: rtl/burst_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram_arbiter
// Purpose  : Round-robin sharing of one 64-bit burst-RAM port between two
//            cache clients, with central minimum command spacing.
// Revision : 1.0 - initial release
// ============================================================================
module burst_ram_arbiter #(
  parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
  parameter int COMMAND_DELAY_INTERVAL   = 13,
  parameter int BURST_BEATS              = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                c0_cmd,
  input  logic                                c0_cmd_en,
  input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] c0_addr,
  input  logic [63:0]                         c0_wr_data,
  input  logic [7:0]                          c0_data_mask,
  output logic                                c0_cmd_ack,
  output logic [63:0]                         c0_rd_data,
  output logic                                c0_rd_data_valid,
  input  logic                                c1_cmd,
  input  logic                                c1_cmd_en,
  input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] c1_addr,
  input  logic [63:0]                         c1_wr_data,
  input  logic [7:0]                          c1_data_mask,
  output logic                                c1_cmd_ack,
  output logic [63:0]                         c1_rd_data,
  output logic                                c1_rd_data_valid,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                         br_wr_data,
  output logic [7:0]                          br_data_mask,
  input  logic [63:0]                         br_rd_data,
  input  logic                                br_rd_data_valid
);

  localparam int c_DLY_W  = $clog2(COMMAND_DELAY_INTERVAL + 1);
  localparam int c_BEAT_W = $clog2(BURST_BEATS + 1);
  localparam logic [c_DLY_W-1:0]  c_DLY_RELOAD = c_DLY_W'(COMMAND_DELAY_INTERVAL);
  localparam logic [c_BEAT_W-1:0] c_LAST_WR    = c_BEAT_W'(BURST_BEATS);
  localparam logic [c_BEAT_W-1:0] c_LAST_RD    = c_BEAT_W'(BURST_BEATS - 1);
  localparam logic [c_BEAT_W-1:0] c_FIRST_WR   = c_BEAT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WRITE_BEATS = 2'd1,
    S_READ_WAIT   = 2'd2
  } state_t;

  state_t                              r_state;
  state_t                              w_next_state;
  logic [c_DLY_W-1:0]                  r_dly;
  logic [c_BEAT_W-1:0]                 r_beat;
  logic                                r_last_grant;
  logic                                r_owner;
  logic                                r_rd_owner_valid;
  logic                                r_cmd;
  logic                                r_cmd_en;
  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] r_addr;
  logic [63:0]                         r_wr_data;
  logic [7:0]                          r_mask;
  logic [1:0]                          r_ack;

  logic                                w_issue;
  logic                                w_winner;
  logic                                w_win_cmd;
  logic                                w_rd_last;
  logic                                w_rd_forward;
  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] w_win_addr;
  logic [63:0]                         w_win_wr_data;
  logic [7:0]                          w_win_mask;
  logic [63:0]                         w_owner_wr_data;

  assign w_win_addr      = w_winner ? c1_addr      : c0_addr;
  assign w_win_wr_data   = w_winner ? c1_wr_data   : c0_wr_data;
  assign w_win_mask      = w_winner ? c1_data_mask : c0_data_mask;
  assign w_owner_wr_data = r_owner  ? c1_wr_data   : c0_wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // On a tie the client that did not win last time is granted.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_winner     = 1'b0;
    w_win_cmd    = 1'b0;
    w_rd_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_dly == '0 && (c0_cmd_en || c1_cmd_en)) begin
          w_issue      = 1'b1;
          w_winner     = (c0_cmd_en && c1_cmd_en) ? ~r_last_grant : c1_cmd_en;
          w_win_cmd    = w_winner ? c1_cmd : c0_cmd;
          w_next_state = w_win_cmd ? S_WRITE_BEATS : S_READ_WAIT;
        end
      end
      S_WRITE_BEATS: begin
        if (r_beat == c_LAST_WR) begin
          w_next_state = S_IDLE;
        end
      end
      S_READ_WAIT: begin
        if (br_rd_data_valid && r_beat == c_LAST_RD) begin
          w_rd_last    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly            <= '0;
      r_beat           <= '0;
      r_last_grant     <= 1'b1;
      r_owner          <= 1'b0;
      r_rd_owner_valid <= 1'b0;
      r_cmd            <= 1'b0;
      r_cmd_en         <= 1'b0;
      r_addr           <= '0;
      r_wr_data        <= '0;
      r_mask           <= '0;
      r_ack            <= 2'b00;
    end else begin
      r_cmd_en <= w_issue;
      r_ack    <= {w_issue & w_winner, w_issue & ~w_winner};

      if (w_issue) begin
        r_dly <= c_DLY_RELOAD;
      end else if (r_dly != '0) begin
        r_dly <= r_dly - 1'b1;
      end

      // r_beat counts beats already presented (writes) or received (reads).
      if (w_issue) begin
        r_last_grant     <= w_winner;
        r_owner          <= w_winner;
        r_cmd            <= w_win_cmd;
        r_addr           <= w_win_addr;
        r_wr_data        <= w_win_wr_data;
        r_mask           <= w_win_mask;
        r_rd_owner_valid <= ~w_win_cmd;
        r_beat           <= w_win_cmd ? c_FIRST_WR : '0;
      end else if (r_state == S_WRITE_BEATS) begin
        r_beat <= r_beat + 1'b1;
        if (r_beat == c_LAST_WR) begin
          r_wr_data <= w_owner_wr_data;
        end
      end else if (r_state == S_READ_WAIT && br_rd_data_valid) begin
        r_beat <= r_beat + 1'b1;
        if (w_rd_last) begin
          r_rd_owner_valid <= 1'b0;
        end
      end
    end
  end

  // Later write beats bypass the register so beat k lands in cycle C+k.
  assign br_wr_data   = (r_state == S_WRITE_BEATS && !r_cmd_en) ? w_owner_wr_data : r_wr_data;
  assign br_cmd       = r_cmd;
  assign br_cmd_en    = r_cmd_en;
  assign br_addr      = r_addr;
  assign br_data_mask = r_mask;

  assign c0_cmd_ack = r_ack[0];
  assign c1_cmd_ack = r_ack[1];

  assign w_rd_forward     = !rst && br_rd_data_valid && (r_state == S_READ_WAIT) && r_rd_owner_valid;
  assign c0_rd_data       = br_rd_data;
  assign c1_rd_data       = br_rd_data;
  assign c0_rd_data_valid = w_rd_forward && !r_owner;
  assign c1_rd_data_valid = w_rd_forward &&  r_owner;

endmodule
`default_nettype wire

// File: tb/tb_burst_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_ram_arbiter
// Purpose  : Directed scoreboard bench for burst_ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_ram_arbiter;

  localparam int AW    = 21;
  localparam int DLY   = 13;
  localparam int BEATS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c0_cmd, c0_cmd_en, c1_cmd, c1_cmd_en;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [63:0]   c0_wr_data, c1_wr_data;
  logic [7:0]    c0_data_mask, c1_data_mask;
  logic          c0_cmd_ack, c1_cmd_ack, c0_rd_data_valid, c1_rd_data_valid;
  logic [63:0]   c0_rd_data, c1_rd_data;
  logic          br_cmd, br_cmd_en, br_rd_data_valid;
  logic [AW-1:0] br_addr;
  logic [63:0]   br_wr_data, br_rd_data;
  logic [7:0]    br_data_mask;

  burst_ram_arbiter #(
    .BURST_RAM_DEPTH_BITWIDTH(AW),
    .COMMAND_DELAY_INTERVAL  (DLY),
    .BURST_BEATS             (BEATS)
  ) dut (
    .clk(clk), .rst(rst),
    .c0_cmd(c0_cmd), .c0_cmd_en(c0_cmd_en), .c0_addr(c0_addr), .c0_wr_data(c0_wr_data),
    .c0_data_mask(c0_data_mask), .c0_cmd_ack(c0_cmd_ack), .c0_rd_data(c0_rd_data),
    .c0_rd_data_valid(c0_rd_data_valid),
    .c1_cmd(c1_cmd), .c1_cmd_en(c1_cmd_en), .c1_addr(c1_addr), .c1_wr_data(c1_wr_data),
    .c1_data_mask(c1_data_mask), .c1_cmd_ack(c1_cmd_ack), .c1_rd_data(c1_rd_data),
    .c1_rd_data_valid(c1_rd_data_valid),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            client;
    bit            cmd;
    logic [AW-1:0] addr;
    logic [7:0]    mask;
  } exp_cmd_t;

  exp_cmd_t    exp_cmd_q[$];
  logic [63:0] exp_wr_q[$];
  logic [63:0] exp_rd0_q[$];
  logic [63:0] exp_rd1_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_v0  = 0;
  int          n_v1  = 0;
  int          wcnt  = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations as the DUT produces them.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ack_without_cmd_en",
            {62'd0, c1_cmd_ack & ~br_cmd_en, c0_cmd_ack & ~br_cmd_en}, 64'd0);
      if (br_cmd_en) begin
        exp_cmd_t e;
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_cmd_en", 64'd1, 64'd0);
        end else begin
          e = exp_cmd_q.pop_front();
          check("br_cmd", {63'd0, br_cmd}, {63'd0, e.cmd});
          check("br_addr", 64'(br_addr), 64'(e.addr));
          check("br_data_mask", 64'(br_data_mask), 64'(e.mask));
          check("c0_cmd_ack", {63'd0, c0_cmd_ack}, {63'd0, e.client == 1'b0});
          check("c1_cmd_ack", {63'd0, c1_cmd_ack}, {63'd0, e.client == 1'b1});
          if (e.cmd) wcnt = BEATS + 1;
        end
      end
      if (wcnt > 0) begin
        if (exp_wr_q.size() == 0) check("wr_beat_unexpected", 64'd1, 64'd0);
        else check("br_wr_data", br_wr_data, exp_wr_q.pop_front());
        wcnt--;
      end
      if (c0_rd_data_valid) begin
        n_v0++;
        if (exp_rd0_q.size() == 0) check("c0_rd_unexpected", 64'd1, 64'd0);
        else check("c0_rd_data", c0_rd_data, exp_rd0_q.pop_front());
      end
      if (c1_rd_data_valid) begin
        n_v1++;
        if (exp_rd1_q.size() == 0) check("c1_rd_unexpected", 64'd1, 64'd0);
        else check("c1_rd_data", c1_rd_data, exp_rd1_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input int n, input logic v);
    if (n == 0) c0_cmd_en = v; else c1_cmd_en = v;
  endtask

  task automatic set_data(input int n, input logic [63:0] d);
    if (n == 0) c0_wr_data = d; else c1_wr_data = d;
  endtask

  task automatic set_req(input int n, input logic cmd, input logic [AW-1:0] a,
                         input logic [63:0] d, input logic [7:0] m);
    if (n == 0) begin
      c0_cmd = cmd; c0_addr = a; c0_wr_data = d; c0_data_mask = m; c0_cmd_en = 1'b1;
    end else begin
      c1_cmd = cmd; c1_addr = a; c1_wr_data = d; c1_data_mask = m; c1_cmd_en = 1'b1;
    end
  endtask

  task automatic expect_cmd(input int n, input logic cmd, input logic [AW-1:0] a, input logic [7:0] m);
    exp_cmd_t e;
    e.client = (n == 1);
    e.cmd    = cmd;
    e.addr   = a;
    e.mask   = m;
    exp_cmd_q.push_back(e);
  endtask

  task automatic wait_ack(input int n, output int c);
    bit got = 1'b0;
    c = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((n == 0 && c0_cmd_ack) || (n == 1 && c1_cmd_ack)) begin
        got = 1'b1;
        c   = cyc;
      end
    end
    if (!got) check($sformatf("ack%0d_timeout", n), 64'd0, 64'd1);
  endtask

  // Write beat k is base*(k+1); the last beat must also be held one cycle.
  task automatic req_write(input int n, input logic [AW-1:0] a, input logic [7:0] m, input logic [63:0] base);
    expect_cmd(n, 1'b1, a, m);
    for (int k = 0; k < BEATS; k++) exp_wr_q.push_back(base * 64'(k + 1));
    exp_wr_q.push_back(base * 64'(BEATS));
    set_req(n, 1'b1, a, base, m);
  endtask

  task automatic finish_write(input int n, input logic [63:0] base, input bit keep, output int c);
    wait_ack(n, c);
    for (int k = 1; k < BEATS; k++) begin
      step();
      set_data(n, base * 64'(k + 1));
      if (k == 1 && !keep) set_en(n, 1'b0);
    end
  endtask

  task automatic req_read(input int n, input logic [AW-1:0] a, input logic [7:0] m);
    expect_cmd(n, 1'b0, a, m);
    set_req(n, 1'b0, a, 64'd0, m);
  endtask

  task automatic ram_beats(input int n, input logic [63:0] base, input int cnt, input bit push, output int last);
    last = -1;
    for (int k = 0; k < cnt; k++) begin
      step();
      br_rd_data       = base + 64'(k);
      br_rd_data_valid = 1'b1;
      last             = cyc;
      if (push) begin
        if (n == 0) exp_rd0_q.push_back(br_rd_data);
        else        exp_rd1_q.push_back(br_rd_data);
      end
    end
    step();
    br_rd_data_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_br_cmd"},       {63'd0, br_cmd},     64'd0);
    check({tag, "_br_cmd_en"},    {63'd0, br_cmd_en},  64'd0);
    check({tag, "_br_addr"},      64'(br_addr),        64'd0);
    check({tag, "_br_wr_data"},   br_wr_data,          64'd0);
    check({tag, "_br_data_mask"}, 64'(br_data_mask),   64'd0);
    check({tag, "_acks"},         {62'd0, c1_cmd_ack, c0_cmd_ack}, 64'd0);
    check({tag, "_rd_valids"},    {62'd0, c1_rd_data_valid, c0_rd_data_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, ca, cb, r, last, v0, v1;
    logic [63:0] wb [3];
    c0_cmd = 0; c0_cmd_en = 0; c0_addr = '0; c0_wr_data = '0; c0_data_mask = '0;
    c1_cmd = 0; c1_cmd_en = 0; c1_addr = '0; c1_wr_data = '0; c1_data_mask = '0;
    br_rd_data = '0; br_rd_data_valid = 0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check_reset_values("reset");
    step();
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) step();

    // Client 0 read at 0x100, four beats returned after six cycles
    v0 = n_v0; v1 = n_v1;
    req_read(0, 21'h100, 8'hFF);
    r = cyc;
    wait_ack(0, c);
    check("t1_ack_latency", 64'(c - r), 64'd1);
    step();
    set_en(0, 1'b0);
    repeat (5) step();
    ram_beats(0, 64'hA000_0000_0000_0100, 4, 1'b1, last);
    repeat (3) step();
    check("t1_c0_valid_beats", 64'(n_v0 - v0), 64'd4);
    check("t1_c1_valid_beats", 64'(n_v1 - v1), 64'd0);

    // Client 1 write at 0x40
    repeat (20) step();
    req_write(1, 21'h40, 8'h0F, 64'h1111_1111_1111_1111);
    finish_write(1, 64'h1111_1111_1111_1111, 1'b0, c);
    repeat (3) step();

    // Tie right after reset: client 0 first, client 1 exactly 14 cycles later
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_write(0, 21'h200, 8'hF0, 64'h0102_0304_0506_0708);
    req_write(1, 21'h300, 8'h3C, 64'h0010_2030_4050_6070);
    finish_write(0, 64'h0102_0304_0506_0708, 1'b0, ca);
    finish_write(1, 64'h0010_2030_4050_6070, 1'b0, cb);
    check("t3_tie_spacing", 64'(cb - ca), 64'(DLY + 1));
    repeat (3) step();

    // Back-to-back writes from client 0 with cmd_en held high
    repeat (20) step();
    wb[0] = 64'h0000_0001_0000_0001;
    wb[1] = 64'h0000_0100_0000_0100;
    wb[2] = 64'h0001_0000_0001_0000;
    ca = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      req_write(0, AW'(21'h400 + 4 * i), 8'(8'h81 + i), wb[i]);
      finish_write(0, wb[i], i < 2, c);
      if (i > 0) check($sformatf("t4_b2b_spacing_%0d", i), 64'(c - ca), 64'(DLY + 1));
      ca = c;
    end
    repeat (3) step();

    // Tie after a client-0 grant: client 1 wins; client 0 waits for read completion
    repeat (20) step();
    req_read(1, 21'h0B0, 8'h55);
    req_read(0, 21'h0A0, 8'hAA);
    wait_ack(1, cb);
    step();
    set_en(1, 1'b0);
    repeat (13) step();
    ram_beats(1, 64'hB100_0000_0000_0000, 4, 1'b1, last);
    wait_ack(0, ca);
    check("t5_after_read_completion", 64'(ca - last), 64'd2);
    step();
    set_en(0, 1'b0);
    ram_beats(0, 64'hC200_0000_0000_0000, 4, 1'b1, last);
    repeat (3) step();

    // Reset during READ_WAIT after two beats
    repeat (20) step();
    v0 = n_v0;
    req_read(0, 21'h055, 8'hA5);
    wait_ack(0, c);
    step();
    set_en(0, 1'b0);
    ram_beats(0, 64'hD300_0000_0000_0000, 2, 1'b1, last);
    rst = 1'b1;
    step();
    @(negedge clk);
    check_reset_values("midread_reset");
    step();
    rst = 1'b0;
    ram_beats(0, 64'hD300_0000_0000_0002, 2, 1'b0, last);
    check("t6_c0_valid_beats", 64'(n_v0 - v0), 64'd2);
    req_read(1, 21'h066, 8'h5A);
    r = cyc;
    wait_ack(1, c);
    check("t6_issue_after_reset", 64'(c - r), 64'd1);
    step();
    set_en(1, 1'b0);
    ram_beats(1, 64'hE400_0000_0000_0000, 4, 1'b1, last);
    repeat (5) step();

    check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
    check("wr_queue_drained",  64'(exp_wr_q.size()),  64'd0);
    check("rd0_queue_drained", 64'(exp_rd0_q.size()), 64'd0);
    check("rd1_queue_drained", 64'(exp_rd1_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
